alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single ALUControl/ALU pair between two requesters: req 0 is the core datapath, req 1 is an auxiliary unit such as an address generator or debug port.
- Round-robin arbitration with a valid/ready handshake on both the request and the response side.
- Latches the winner's ALUOp, FuncCode and operands, then drives them to the shared ALU for one cycle.
- Registers the result and zero flag and returns them to the owner. One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid0 / req_valid1  in  1  request present.
- req_ready0 / req_ready1  out  1  request accepted this cycle.
- req_aluop0 / req_aluop1  in  2  ALUOp for the request.
- req_func0 / req_func1  in  6  FuncCode for the request.
- req_a0 / req_a1  in  WIDTH  operand A.
- req_b0 / req_b1  in  WIDTH  operand B.
- resp_valid0 / resp_valid1  out  1  result available.
- resp_ready0 / resp_ready1  in  1  requester takes the result.
- resp_result  out  WIDTH  registered ALU result, shared by both requesters.
- resp_zero  out  1  registered ALU zero flag.
- alu_op  out  2  to ALUControl ALUOp.
- alu_func  out  6  to ALUControl FuncCode.
- alu_a  out  WIDTH  to ALU operand A.
- alu_b  out  WIDTH  to ALU operand B.
- alu_result  in  WIDTH  combinational ALU result.
- alu_zero  in  1  combinational ALU zero flag.

Behaviour:
- One clock domain (clk). Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: the latched operation is applied to the shared ALU for exactly one cycle.
  - RESP: the registered result is presented to the owning requester until taken.
- Reset values:
  - state=IDLE, owner=0, rr_ptr=0.
  - alu_op=0, alu_func=0, alu_a=0, alu_b=0.
  - resp_result=0, resp_zero=0.
  - All req_ready and resp_valid outputs = 0.
- IDLE:
  - req_ready is combinational and asserted only for the granted requester, only in IDLE.
  - Grant goes to the only valid requester. If both are valid, grant goes to rr_ptr.
  - On grant: latch aluop/func/a/b into alu_op/alu_func/alu_a/alu_b, set owner, go to EXEC.
  - No valid requester: stay in IDLE, ALU outputs hold their last values.
- EXEC:
  - ALU inputs are stable from the latch.
  - Capture alu_result into resp_result and alu_zero into resp_zero, go to RESP.
  - No request is accepted.
- RESP:
  - resp_valid[owner]=1; resp_valid of the other requester = 0.
  - resp_result and resp_zero are held stable.
  - When resp_ready[owner]=1: set rr_ptr = ~owner and go to IDLE. resp_valid drops the next cycle.
  - resp_ready of the non-owner is ignored.
  - A back-pressure stall of any length is legal and holds all outputs.
- Latency: accept in cycle T, ALU driven in T+1, resp_valid in T+2.
- Minimum issue interval is 3 cycles, including a zero-wait response.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- A request that is not granted must be held by its requester. The arbiter never drops a request.
- Arithmetic: pure pass-through. No width conversion.
- Invalid FuncCode values are forwarded unchanged. The result is whatever the ALU returns.
- Reset mid-operation (in EXEC or RESP): the operation is abandoned, no response is issued, and all reset values apply on the next cycle.
- req_valid held during reset is not granted until the first IDLE cycle after reset is released.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_PERF_EN.
- Enabled:
  - Adds output ports grant_cnt0 and grant_cnt1, each CNT_W bits, and output port stall_cnt, CNT_W bits.
  - grant_cnt0/grant_cnt1 increment on each grant to that requester.
  - stall_cnt increments every RESP cycle in which resp_ready[owner]=0.
  - All three saturate at all-ones and reset to 0.
- Disabled: these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Req0 only, aluop=2, func=32, a=5, b=7, resp_ready0=1 -> req_ready0 in T; alu_op=2, alu_func=32 in T+1; resp_valid0=1 with resp_result=12, resp_zero=0 in T+2; back in IDLE at T+3.
- Both valid from the first cycle after reset, r0: func=34, a=9, b=9; r1: func=36, a=0xF0, b=0x3C -> r0 served first with result=0, zero=1; r1 then granted with result=0x30; the next contention goes to r0.
- Req1: aluop=1, a=3, b=3, resp_ready1 low for 4 cycles -> resp_valid1 held 4+ cycles, resp_result=0 and resp_zero=1 stable, req0 (valid throughout) not granted until the cycle after handshake.
- rst asserted for one cycle while in EXEC -> next cycle: state IDLE, all resp_valid=0, resp_result=0, no response ever issued for the aborted operation.
- Both requesters valid for 10 back-to-back operations -> grant order 0,1,0,1...; with PERF_EN, grant_cnt0=5 and grant_cnt1=5.
- With PERF_EN, stall_cnt preset near all-ones plus extra stall cycles -> stall_cnt saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one ALUControl/ALU pair between two requesters
// Optional performance counters (grant_cnt0, grant_cnt1, stall_cnt) exist only when
// the macro ALU_SHARE_ARBITER_PERF_EN is defined.

module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [1:0]       req_aluop0,
  input  logic [1:0]       req_aluop1,
  input  logic [5:0]       req_func0,
  input  logic [5:0]       req_func1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  input  logic             resp_ready0,
  input  logic             resp_ready1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [1:0]       alu_op,
  output logic [5:0]       alu_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_SHARE_ARBITER_PERF_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   rr_ptr;
  logic   grant0;
  logic   grant1;
  logic   resp_take;

  // Grant decision: only in IDLE and never while reset is held; rr_ptr breaks ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req_valid0 && (!req_valid1 || !rr_ptr)) begin
        grant0 = 1'b1;
      end else if (req_valid1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;
  assign resp_take  = (state == RESP) && (owner ? resp_ready1 : resp_ready0);

  // Arbitration FSM: latch the winner, drive the ALU for one cycle, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      alu_op      <= '0;
      alu_func    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            alu_op   <= req_aluop0;
            alu_func <= req_func0;
            alu_a    <= req_a0;
            alu_b    <= req_b0;
            owner    <= 1'b0;
            state    <= EXEC;
          end else if (grant1) begin
            alu_op   <= req_aluop1;
            alu_func <= req_func1;
            alu_a    <= req_a1;
            alu_b    <= req_b1;
            owner    <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_valid0 <= !owner;
          resp_valid1 <= owner;
          state       <= RESP;
        end
        RESP: begin
          if (resp_take) begin
            resp_valid0 <= 1'b0;
            resp_valid1 <= 1'b0;
            rr_ptr      <= ~owner;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SHARE_ARBITER_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating grant and back-pressure counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (grant0 && grant_cnt0 != CNT_MAX) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (grant1 && grant_cnt1 != CNT_MAX) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
      if (state == RESP && !resp_take && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU and arbitration model

module tb_alu_share_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid0, req_valid1;
  logic             req_ready0, req_ready1;
  logic [1:0]       req_aluop0, req_aluop1;
  logic [5:0]       req_func0, req_func1;
  logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
  logic             resp_valid0, resp_valid1;
  logic             resp_ready0, resp_ready1;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic [1:0]       alu_op;
  logic [5:0]       alu_func;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
`ifdef ALU_SHARE_ARBITER_PERF_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_aluop0(req_aluop0), .req_aluop1(req_aluop1),
    .req_func0(req_func0), .req_func1(req_func1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_op(alu_op), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
`ifdef ALU_SHARE_ARBITER_PERF_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
    .alu_zero(alu_zero)
  );

  // MIPS-style ALUControl + ALU; unknown FuncCodes yield a ^ b.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op, input logic [5:0] f,
                                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        case (f)
          6'd32:   return a + b;
          6'd34:   return a - b;
          6'd36:   return a & b;
          6'd37:   return a | b;
          6'd42:   return ($signed(a) < $signed(b)) ? 1 : 0;
          default: return a ^ b;
        endcase
      end
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_func, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one operation in flight, round-robin pointer = other of last owner.
  bit               in_flight  = 0;
  bit               resp_phase = 0;
  int               stage      = 0;
  bit               own        = 0;
  bit               rr_m       = 0;
  int               gm0 = 0, gm1 = 0, sm = 0;
  logic [1:0]       p_op;
  logic [5:0]       p_f;
  logic [WIDTH-1:0] p_a, p_b;
  logic             e0, e1;
  exp_t             ex;

  bit   rand_rdy  = 0;
  logic force_rdy0 = 1'b1;
  logic force_rdy1 = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      resp_ready0 = ($urandom_range(0, 2) != 0);
      resp_ready1 = ($urandom_range(0, 2) != 0);
    end else begin
      resp_ready0 = force_rdy0;
      resp_ready1 = force_rdy1;
    end
  end

  // Monitor / scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
`ifdef ALU_SHARE_ARBITER_PERF_EN
    chk("grant_cnt0", grant_cnt0, gm0);
    chk("grant_cnt1", grant_cnt1, gm1);
    chk("stall_cnt", stall_cnt, sm);
`endif
    if (stage == 1) begin
      chk("alu_op", alu_op, p_op);
      chk("alu_func", alu_func, p_f);
      chk("alu_a", alu_a, p_a);
      chk("alu_b", alu_b, p_b);
      stage = 2;
    end else if (stage == 2) begin
      resp_phase = 1;
      stage = 0;
    end

    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !in_flight) begin
      e0 = req_valid0 && (!req_valid1 || rr_m == 1'b0);
      e1 = req_valid1 && !e0;
    end
    chk("req_ready0", req_ready0, e0);
    chk("req_ready1", req_ready1, e1);

    if (!rst && req_valid0 && req_ready0) begin
      own = 0; p_op = req_aluop0; p_f = req_func0; p_a = req_a0; p_b = req_b0;
      ex.res = alu_fn(p_op, p_f, p_a, p_b); ex.z = (ex.res == '0);
      q0.push_back(ex);
      in_flight = 1; stage = 1; gm0 = sat(gm0);
    end else if (!rst && req_valid1 && req_ready1) begin
      own = 1; p_op = req_aluop1; p_f = req_func1; p_a = req_a1; p_b = req_b1;
      ex.res = alu_fn(p_op, p_f, p_a, p_b); ex.z = (ex.res == '0);
      q1.push_back(ex);
      in_flight = 1; stage = 1; gm1 = sat(gm1);
    end

    chk("resp_valid0", resp_valid0, resp_phase && own == 0);
    chk("resp_valid1", resp_valid1, resp_phase && own == 1);
    if (resp_valid0) begin
      chk("resp0_expected", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        chk("resp_result0", resp_result, q0[0].res);
        chk("resp_zero0", resp_zero, q0[0].z);
        if (resp_ready0) void'(q0.pop_front());
      end
    end
    if (resp_valid1) begin
      chk("resp1_expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        chk("resp_result1", resp_result, q1[0].res);
        chk("resp_zero1", resp_zero, q1[0].z);
        if (resp_ready1) void'(q1.pop_front());
      end
    end
    if (resp_phase) begin
      if (own ? resp_ready1 : resp_ready0) begin
        resp_phase = 0; in_flight = 0; rr_m = ~own;
      end else begin
        sm = sat(sm);
      end
    end

    if (rst) begin
      q0.delete(); q1.delete();
      in_flight = 0; resp_phase = 0; stage = 0; rr_m = 0;
      gm0 = 0; gm1 = 0; sm = 0;
    end
  end

  task automatic send0(input logic [1:0] op, input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int k = 0;
    req_valid0 = 1'b1; req_aluop0 = op; req_func0 = f; req_a0 = a; req_b0 = b;
    while (1) begin
      @(negedge clk);
      if (req_ready0) break;
      k++;
      if (k > 300) begin
        n_checks++; n_fail++;
        $display("FAIL send0_timeout: no req_ready0 within 300 cycles at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [1:0] op, input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int k = 0;
    req_valid1 = 1'b1; req_aluop1 = op; req_func1 = f; req_a1 = a; req_b1 = b;
    while (1) begin
      @(negedge clk);
      if (req_ready1) break;
      k++;
      if (k > 300) begin
        n_checks++; n_fail++;
        $display("FAIL send1_timeout: no req_ready1 within 300 cycles at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid1 = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((in_flight || q0.size() != 0 || q1.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout: responses still pending after %0d cycles", k);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic rand_op(output logic [1:0] op, output logic [5:0] f, output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    logic [5:0] fl [6];
    fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37; fl[4] = 6'd42; fl[5] = 6'($urandom);
    op = 2'($urandom_range(0, 3));
    f  = fl[$urandom_range(0, 5)];
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    logic [WIDTH-1:0] a, b;
    rst = 1'b1;
    req_valid0 = 0; req_valid1 = 0;
    req_aluop0 = 0; req_aluop1 = 0; req_func0 = 0; req_func1 = 0;
    req_a0 = 0; req_a1 = 0; req_b0 = 0; req_b1 = 0;
    resp_ready0 = 1; resp_ready1 = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid0", resp_valid0, 0);
    chk("rst_resp_valid1", resp_valid1, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_zero", resp_zero, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from the core datapath: 5 + 7.
    send0(2'd2, 6'd32, 32'd5, 32'd7);
    wait_idle();

    // Both requesters valid through reset release; r0 first, then r1, then contention back to r0.
    rst = 1'b1;
    fork
      begin send0(2'd2, 6'd34, 32'd9, 32'd9); send0(2'd2, 6'd37, 32'h11, 32'h22); end
      begin send1(2'd2, 6'd36, 32'hF0, 32'h3C); send1(2'd0, 6'd0, 32'd100, 32'd23); end
      begin repeat (3) begin @(posedge clk); #1; end rst = 1'b0; end
    join
    wait_idle();

    // Back-pressure on r1 while r0 waits.
    force_rdy1 = 1'b0;
    send1(2'd1, 6'd0, 32'd3, 32'd3);
    fork
      send0(2'd2, 6'd32, 32'd1, 32'd2);
      begin repeat (6) begin @(posedge clk); #1; end force_rdy1 = 1'b1; end
    join
    wait_idle();

    // Reset while the operation is in EXEC.
    send0(2'd0, 6'd0, 32'd11, 32'd22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid0", resp_valid0, 0);
    chk("abort_resp_valid1", resp_valid1, 0);
    chk("abort_resp_result", resp_result, 0);
    chk("abort_resp_zero", resp_zero, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_op", alu_op, 0);
    repeat (6) begin @(posedge clk); #1; end

    // Ten back-to-back operations with both requesters continuously valid.
    do_reset();
    fork
      repeat (5) begin rand_op(op, f, a, b); send0(op, f, a, b); end
      begin
        logic [1:0] op1; logic [5:0] f1; logic [WIDTH-1:0] a1, b1;
        repeat (5) begin rand_op(op1, f1, a1, b1); send1(op1, f1, a1, b1); end
      end
    join
    wait_idle();
`ifdef ALU_SHARE_ARBITER_PERF_EN
    chk("b2b_grant_cnt0", grant_cnt0, 5);
    chk("b2b_grant_cnt1", grant_cnt1, 5);
`endif

    // Long stall on r0, long enough to saturate the stall counter.
    force_rdy0 = 1'b0;
    send0(2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1);
    repeat (20) begin @(posedge clk); #1; end
    force_rdy0 = 1'b1;
    wait_idle();
`ifdef ALU_SHARE_ARBITER_PERF_EN
    chk("stall_cnt_sat", stall_cnt, CNT_MAX);
`endif

    // Random traffic with random gaps and random response back-pressure.
    rand_rdy = 1;
    fork
      repeat (30) begin
        logic [1:0] opa; logic [5:0] fa; logic [WIDTH-1:0] aa, ba;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rand_op(opa, fa, aa, ba);
        send0(opa, fa, aa, ba);
      end
      repeat (30) begin
        logic [1:0] opb; logic [5:0] fb; logic [WIDTH-1:0] ab, bb;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rand_op(opb, fb, ab, bb);
        send1(opb, fb, ab, bb);
      end
    join
    rand_rdy = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
